// File: rtl/cpu_core.sv
// cpu_core: single-cycle RV32I core with debug-loaded instruction memory and local data memory.
// Every instruction fetches, executes and writes back within one clk cycle.
module cpu_core #(
  parameter int XLEN = 32,
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic            clk,
  input logic            rst,
  input logic            dbg_wr_en,
  input logic [XLEN-1:0] dbg_addr,
  input logic [XLEN-1:0] dbg_instr
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);
  logic [XLEN-1:0] imem [IMEM_WORDS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];
  logic [XLEN-1:0] regs [0:31];
  logic [XLEN-1:0] pc, instr, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] alu_b, alu, wd, npc, pc4, ea_i, ea_s, ld;
  logic signed [XLEN-1:0] sra;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rd, shamt;
  logic sub, br, we, st, eq, lt, ltu, unused;
  assign instr = imem[pc[IA+1:2]];
  assign op = instr[6:0];
  assign rd = instr[11:7];
  assign f3 = instr[14:12];
  assign rs1_v = instr[19:15] == 5'd0 ? '0 : regs[instr[19:15]];
  assign rs2_v = instr[24:20] == 5'd0 ? '0 : regs[instr[24:20]];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc4 = pc + 4;
  assign ea_i = rs1_v + imm_i;
  assign ea_s = rs1_v + imm_s;
  assign ld = dmem[ea_i[DA+1:2]];
  assign st = op == 7'h23 && f3 == 3'd2;
  // bit 30 selects SUB only for register ops; for shifts it selects arithmetic in both forms
  assign alu_b = op == 7'h33 ? rs2_v : imm_i;
  assign sub = op == 7'h33 && instr[30];
  assign shamt = alu_b[4:0];
  assign sra = $signed(rs1_v) >>> shamt;
  always_comb begin
    alu = rs1_v + alu_b;
    case (f3)
      3'd0: alu = sub ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1: alu = rs1_v << shamt;
      3'd2: alu = {{(XLEN-1){1'b0}}, $signed(rs1_v) < $signed(alu_b)};
      3'd3: alu = {{(XLEN-1){1'b0}}, rs1_v < alu_b};
      3'd4: alu = rs1_v ^ alu_b;
      3'd5: alu = instr[30] ? sra : rs1_v >> shamt;
      3'd6: alu = rs1_v | alu_b;
      default: alu = rs1_v & alu_b;
    endcase
  end
  assign eq = rs1_v == rs2_v;
  assign lt = $signed(rs1_v) < $signed(rs2_v);
  assign ltu = rs1_v < rs2_v;
  assign br = op == 7'h63 && (f3 == 3'd0 ? eq : f3 == 3'd1 ? !eq : f3 == 3'd4 ? lt :
              f3 == 3'd5 ? !lt : f3 == 3'd6 ? ltu : f3 == 3'd7 ? !ltu : 1'b0);
  always_comb begin
    we = 1'b1;
    wd = alu;
    case (op)
      7'h37: wd = imm_u;
      7'h17: wd = pc + imm_u;
      7'h6f, 7'h67: wd = pc4;
      7'h03: begin we = f3 == 3'd2; wd = ld; end
      7'h13, 7'h33: wd = alu;
      default: we = 1'b0;
    endcase
  end
  assign npc = op == 7'h6f ? pc + imm_j : op == 7'h67 ? {ea_i[XLEN-1:1], 1'b0} : br ? pc + imm_b : pc4;
  assign unused = ^{dbg_addr[XLEN-1:IA+2], dbg_addr[1:0], ea_s[XLEN-1:DA+2], ea_s[1:0]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= npc;
      if (we && rd != 5'd0) regs[rd] <= wd;
    end
  end
  // a store racing with reset is dropped
  always_ff @(posedge clk) begin
    if (dbg_wr_en) imem[dbg_addr[IA+1:2]] <= dbg_instr;
    if (rst && st) dmem[ea_s[DA+1:2]] <= rs2_v;
  end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: loads a small RV32I program through the debug port and checks pc/register
// results per instruction, plus reset mid-run and debug write over the executing word.
module tb_cpu_core;
  logic clk = 1'b0, rst = 1'b0, dbg_wr_en = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_instr = '0;
  int checks = 0, errors = 0;
  typedef struct { logic [31:0] addr, instr; bit wr; logic [4:0] rd; logic [31:0] val, npc; } vec_t;
  typedef struct { string name; bit wr; logic [4:0] rd; logic [31:0] val, npc; } exp_t;
  vec_t tbl[23];
  exp_t sb[$];
  cpu_core dut (.clk(clk), .rst(rst), .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr));
  always #5 clk = ~clk;
  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] w);
    dbg_wr_en = 1'b1; dbg_addr = a; dbg_instr = w;
    @(posedge clk); #1;
    dbg_wr_en = 1'b0;
  endtask
  task automatic step(input vec_t v, input string n);
    exp_t e;
    sb.push_back('{n, v.wr, v.rd, v.val, v.npc});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({e.name, " pc"}, dut.pc, e.npc);
    if (e.wr) chk({e.name, " rd"}, dut.regs[e.rd], e.val);
  endtask
  task automatic pulse_reset();
    rst = 1'b0; #1;
    chk("rst pc", dut.pc, 32'h0);
    chk("rst x1", dut.regs[1], 32'h0);
    chk("rst x15", dut.regs[15], 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask
  initial begin
    tbl[0]  = '{32'd0,   i_t(12'd12, 5'd0, 3'd0, 5'd1, 7'h13), 1, 5'd1, 32'd12, 32'd4};
    tbl[1]  = '{32'd4,   i_t(12'd2, 5'd0, 3'd0, 5'd2, 7'h13), 1, 5'd2, 32'd2, 32'd8};
    tbl[2]  = '{32'd8,   b_t(13'd24, 5'd0, 5'd1, 3'd5), 0, 5'd0, 32'd0, 32'd32};
    tbl[3]  = '{32'd32,  b_t(13'd16, 5'd2, 5'd1, 3'd4), 0, 5'd0, 32'd0, 32'd36};
    tbl[4]  = '{32'd36,  i_t(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13), 1, 5'd1, 32'hFFFFFFFF, 32'd40};
    tbl[5]  = '{32'd40,  i_t(12'd1, 5'd0, 3'd0, 5'd2, 7'h13), 1, 5'd2, 32'd1, 32'd44};
    tbl[6]  = '{32'd44,  r_t(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 1, 5'd3, 32'hFFFFFFFE, 32'd48};
    tbl[7]  = '{32'd48,  r_t(7'h00, 5'd2, 5'd1, 3'd2, 5'd4), 1, 5'd4, 32'd1, 32'd52};
    tbl[8]  = '{32'd52,  r_t(7'h00, 5'd2, 5'd1, 3'd3, 5'd5), 1, 5'd5, 32'd0, 32'd56};
    tbl[9]  = '{32'd56,  i_t(12'h404, 5'd1, 3'd5, 5'd6, 7'h13), 1, 5'd6, 32'hFFFFFFFF, 32'd60};
    tbl[10] = '{32'd60,  s_t(12'd0, 5'd1, 5'd0), 0, 5'd0, 32'd0, 32'd64};
    tbl[11] = '{32'd64,  i_t(12'd0, 5'd0, 3'd2, 5'd7, 7'h03), 1, 5'd7, 32'hFFFFFFFF, 32'd68};
    tbl[12] = '{32'd68,  j_t(21'd8, 5'd8), 1, 5'd8, 32'd72, 32'd76};
    tbl[13] = '{32'd76,  i_t(12'd5, 5'd0, 3'd0, 5'd0, 7'h13), 1, 5'd0, 32'd0, 32'd80};
    tbl[14] = '{32'd80,  {20'h12345, 5'd9, 7'h37}, 1, 5'd9, 32'h12345000, 32'd84};
    tbl[15] = '{32'd84,  {20'h00001, 5'd10, 7'h17}, 1, 5'd10, 32'h00001054, 32'd88};
    tbl[16] = '{32'd88,  i_t(12'h0FF, 5'd9, 3'd4, 5'd11, 7'h13), 1, 5'd11, 32'h123450FF, 32'd92};
    tbl[17] = '{32'd92,  i_t(12'd28, 5'd1, 3'd5, 5'd12, 7'h13), 1, 5'd12, 32'h0000000F, 32'd96};
    tbl[18] = '{32'd96,  r_t(7'h00, 5'd2, 5'd2, 3'd1, 5'd13), 1, 5'd13, 32'd2, 32'd100};
    tbl[19] = '{32'd100, b_t(13'd8, 5'd1, 5'd2, 3'd6), 0, 5'd0, 32'd0, 32'd108};
    tbl[20] = '{32'd108, i_t(12'd201, 5'd0, 3'd0, 5'd14, 7'h67), 1, 5'd14, 32'd112, 32'd200};
    tbl[21] = '{32'd200, i_t(12'd7, 5'd0, 3'd0, 5'd15, 7'h13), 1, 5'd15, 32'd7, 32'd204};
    tbl[22] = '{32'd204, j_t(21'd0, 5'd0), 1, 5'd0, 32'd0, 32'd204};
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[k]) load(tbl[k].addr, tbl[k].instr);
    chk("reset pc", dut.pc, 32'h0);
    chk("reset x1", dut.regs[1], 32'h0);
    chk("reset x0", dut.regs[0], 32'h0);
    rst = 1'b1;
    foreach (tbl[k]) step(tbl[k], $sformatf("run1 v%0d", k));
    pulse_reset();
    foreach (tbl[k]) step(tbl[k], $sformatf("run2 v%0d", k));
    pulse_reset();
    for (int k = 0; k < 3; k++) step(tbl[k], $sformatf("run3 v%0d", k));
    dbg_wr_en = 1'b1; dbg_addr = 32'd32; dbg_instr = i_t(12'd99, 5'd0, 3'd0, 5'd16, 7'h13);
    step('{32'd32, 32'd0, 1, 5'd16, 32'd0, 32'd36}, "dbg old word");
    dbg_wr_en = 1'b0;
    pulse_reset();
    for (int k = 0; k < 3; k++) step(tbl[k], $sformatf("run4 v%0d", k));
    step('{32'd32, 32'd0, 1, 5'd16, 32'd99, 32'd36}, "dbg new word");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
